load_port_sched: RTL and testbench

- Schedules the single data-memory load port among NREQ load requesters: the in-order load issue slot plus the replay slots of the stalled-instruction queue.
- Arbitrates round-robin and issues at most one memory load per cycle.
- Tracks outstanding loads in an in-order tag FIFO and returns each result with its destination register.
- Maintains a per-register pending-load scoreboard that the decode stage uses for hazard stalls.

---
 rtl/load_port_sched.sv | 186 ++++++++++++++++++
 tb/tb_load_port_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_port_sched.sv
// load_port_sched: round-robin scheduler for the single data-memory load port.
// It arbitrates NREQ load requesters, issues at most one load per cycle, and
// tracks in-flight loads in an in-order tag FIFO. Writebacks carry the
// destination register of each load, and a per-register pending-load
// scoreboard drives busy[].
// Optional feature: define LOAD_PORT_SCHED_STATS_EN to add the stat_grants and
// stat_stall counters.
module load_port_sched #(
    parameter  int NREQ    = 4,
    parameter  int MAX_OUT = 8,
    parameter  int PCNT_W  = 3,
    localparam int SRC_W   = $clog2(NREQ),
    localparam int OUT_W   = $clog2(MAX_OUT) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_addr,
    input  logic [NREQ*4-1:0]    req_rt,
    output logic [NREQ-1:0]      req_ready,
    output logic                 mem_en,
    output logic [15:0]          mem_addr,
    input  logic                 mem_ready,
    input  logic [15:0]          mem_data,
    output logic                 wb_valid,
    output logic [3:0]           wb_rt,
    output logic [15:0]          wb_data,
    output logic [SRC_W-1:0]     wb_src,
    output logic [15:0]          busy,
    output logic [OUT_W-1:0]     outstanding,
`ifdef LOAD_PORT_SCHED_STATS_EN
    output logic [31:0]          stat_grants,
    output logic [31:0]          stat_stall,
`endif
    output logic                 orphan_err
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

    logic [15:0]       addr_arr [NREQ];
    logic [3:0]        rt_arr   [NREQ];
    logic [PCNT_W-1:0] pend_cnt [16];
    logic [NREQ-1:0]   elig;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  scan_idx;
    logic              grant;
    logic              pop;
    logic [3:0]        grant_rt;
    logic [15:0]       grant_addr;
    logic [3:0]        head_rt;
    logic [15:0]       pend_inc;
    logic [15:0]       pend_dec;

    logic [3:0]        fifo_rt  [MAX_OUT];
    logic [SRC_W-1:0]  fifo_src [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Unpack request buses; a requester is eligible unless its rt counter is saturated
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[16*i +: 16];
            rt_arr[i]   = req_rt[4*i +: 4];
            elig[i]     = req_valid[i] && (pend_cnt[rt_arr[i]] != PCNT_MAX);
        end
    end

    // Round-robin search from rr_ptr; no grant while the tag FIFO is full
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = SRC_W'((32'(rr_ptr) + k) % NREQ);
            if (!grant && elig[scan_idx]) begin
                grant     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (outstanding == OUT_W'(MAX_OUT)) begin
            grant = 1'b0;
        end
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_addr = addr_arr[grant_idx];
    assign grant_rt   = rt_arr[grant_idx];
    assign head_rt    = fifo_rt[rd_ptr];
    assign pop        = mem_ready && (outstanding != '0);

    // Per-register increment/decrement requests and the busy view of the scoreboard
    always_comb begin
        for (int unsigned r = 0; r < 16; r++) begin
            pend_inc[r] = grant && (grant_rt == 4'(r));
            pend_dec[r] = pop && (head_rt == 4'(r));
            busy[r]     = (pend_cnt[r] != '0);
        end
    end

    // Tag FIFO storage; contents are only meaningful between rd_ptr and wr_ptr
    always_ff @(posedge clk) begin
        if (grant) begin
            fifo_rt[wr_ptr]  <= grant_rt;
            fifo_src[wr_ptr] <= grant_idx;
        end
    end

    // Pending-load counters; a simultaneous issue and return on one register cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < 16; r++) begin
                pend_cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < 16; r++) begin
                if (pend_inc[r] && !pend_dec[r]) begin
                    pend_cnt[r] <= pend_cnt[r] + PCNT_W'(1);
                end else if (pend_dec[r] && !pend_inc[r]) begin
                    pend_cnt[r] <= pend_cnt[r] - PCNT_W'(1);
                end
            end
        end
    end

    // Issue, return, pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            wb_valid    <= 1'b0;
            wb_rt       <= '0;
            wb_data     <= '0;
            wb_src      <= '0;
            orphan_err  <= 1'b0;
        end else begin
            mem_en   <= grant;
            wb_valid <= pop;
            if (grant) begin
                mem_addr <= grant_addr;
                wr_ptr   <= wr_ptr + PTR_W'(1);
                rr_ptr   <= (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + SRC_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                wb_rt   <= head_rt;
                wb_src  <= fifo_src[rd_ptr];
                wb_data <= mem_data;
            end
            if (mem_ready && (outstanding == '0)) begin
                orphan_err <= 1'b1;
            end
            case ({grant, pop})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef LOAD_PORT_SCHED_STATS_EN
    // Grant and stall-cycle counters, free-running modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant) begin
                stat_grants <= stat_grants + 32'd1;
            end
            if ((|req_valid) && !grant) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_port_sched.sv
// Directed testbench for load_port_sched using the default parameters
// (NREQ=4, MAX_OUT=8, PCNT_W=3).
module tb_load_port_sched;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*16-1:0] req_addr;
    logic [NREQ*4-1:0] req_rt;
    logic [NREQ-1:0]   req_ready;
    logic              mem_en;
    logic [15:0]       mem_addr;
    logic              mem_ready;
    logic [15:0]       mem_data;
    logic              wb_valid;
    logic [3:0]        wb_rt;
    logic [15:0]       wb_data;
    logic [1:0]        wb_src;
    logic [15:0]       busy;
    logic [3:0]        outstanding;
    logic              orphan_err;
`ifdef LOAD_PORT_SCHED_STATS_EN
    logic [31:0]       stat_grants;
    logic [31:0]       stat_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    load_port_sched #(.NREQ(4), .MAX_OUT(8), .PCNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_rt      (req_rt),
        .req_ready   (req_ready),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .wb_valid    (wb_valid),
        .wb_rt       (wb_rt),
        .wb_data     (wb_data),
        .wb_src      (wb_src),
        .busy        (busy),
        .outstanding (outstanding),
`ifdef LOAD_PORT_SCHED_STATS_EN
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall),
`endif
        .orphan_err  (orphan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] addr, input logic [3:0] rt);
        req_addr[16*i +: 16] = addr;
        req_rt[4*i +: 4]     = rt;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_rt    = '0;
        mem_ready = 1'b0;
        mem_data  = '0;

        // ---- reset state ----
        step();
        step();
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_orphan", 32'(orphan_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        step();

        // ---- single load: requester 0, addr 0x0010, rt 3 ----
        set_req(0, 16'h0010, 4'd3);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("t1_mem_en", 32'(mem_en), 1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        chk("t1_busy_issue", 32'(busy), 32'h0008);
        chk("t1_outstanding", 32'(outstanding), 1);
        step();
        chk("t1_mem_en_pulse", 32'(mem_en), 0);
        chk("t1_busy_wait", 32'(busy), 32'h0008);
        step();
        mem_ready = 1'b1;
        mem_data  = 16'hBEEF;
        chk("t1_busy_pre_wb", 32'(busy), 32'h0008);
        chk("t1_wb_early", 32'(wb_valid), 0);
        step();
        mem_ready = 1'b0;
        chk("t1_wb_valid", 32'(wb_valid), 1);
        chk("t1_wb_rt", 32'(wb_rt), 3);
        chk("t1_wb_data", 32'(wb_data), 32'hBEEF);
        chk("t1_wb_src", 32'(wb_src), 0);
        chk("t1_busy_clear", 32'(busy), 0);
        chk("t1_out_zero", 32'(outstanding), 0);
        step();
        chk("t1_wb_pulse", 32'(wb_valid), 0);

        // ---- round-robin with all four valid, no returns ----
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 16'h0100 + 16'(i), 4'(4 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            chk("rr_mem_en", 32'(mem_en), 1);
            chk("rr_mem_addr", 32'(mem_addr), 32'h0100 + 32'(k % 4));
        end
        chk("rr_full_out", 32'(outstanding), 8);
        chk("rr_full_ready", 32'(req_ready), 0);
        chk("rr_busy", 32'(busy), 32'h00F0);
        step();
        chk("rr_full_ready2", 32'(req_ready), 0);
        chk("rr_full_mem_en", 32'(mem_en), 0);
        chk("rr_full_out2", 32'(outstanding), 8);

        // drain in issue order
        req_valid = '0;
        mem_ready = 1'b1;
        mem_data  = 16'hA000;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("dr_wb_valid", 32'(wb_valid), 1);
            chk("dr_wb_src", 32'(wb_src), 32'(k % 4));
            chk("dr_wb_rt", 32'(wb_rt), 32'(4 + k % 4));
            chk("dr_wb_data", 32'(wb_data), 32'hA000 + 32'(k));
            mem_data = 16'hA000 + 16'(k + 1);
        end
        mem_ready = 1'b0;
        chk("dr_out", 32'(outstanding), 0);
        chk("dr_busy", 32'(busy), 0);
        chk("dr_orphan", 32'(orphan_err), 0);

        // ---- pending-counter saturation on rt 5 ----
        set_req(0, 16'h0200, 4'd5);
        req_valid = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("sat_ready", 32'(req_ready), 32'h1);
            step();
        end
        chk("sat_masked", 32'(req_ready), 0);
        chk("sat_out7", 32'(outstanding), 7);
        chk("sat_busy", 32'(busy), 32'h0020);
        step();
        chk("sat_masked2", 32'(req_ready), 0);
        chk("sat_no_issue", 32'(mem_en), 0);
        mem_ready = 1'b1;
        mem_data  = 16'h5555;
        #1;
        chk("sat_masked3", 32'(req_ready), 0);
        step();
        mem_ready = 1'b0;
        chk("sat_ret_wb", 32'(wb_valid), 1);
        chk("sat_ret_out", 32'(outstanding), 6);
        #1;
        chk("sat_regrant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("sat_mem_en", 32'(mem_en), 1);
        chk("sat_mem_addr", 32'(mem_addr), 32'h0200);
        chk("sat_out_back", 32'(outstanding), 7);
        mem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("sat_dr_rt", 32'(wb_rt), 5);
        end
        mem_ready = 1'b0;
        chk("sat_dr_out", 32'(outstanding), 0);
        chk("sat_dr_busy", 32'(busy), 0);

        // ---- simultaneous grant and return on rt 2 (rr_ptr now 1) ----
        set_req(1, 16'h0300, 4'd2);
        req_valid = 4'b0010;
        #1;
        chk("sim_ready1", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        chk("sim_busy_pre", 32'(busy), 32'h0004);
        chk("sim_out_pre", 32'(outstanding), 1);
        set_req(2, 16'h0304, 4'd2);
        req_valid = 4'b0100;
        mem_ready = 1'b1;
        mem_data  = 16'h1234;
        #1;
        chk("sim_ready2", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        mem_ready = 1'b0;
        chk("sim_out", 32'(outstanding), 1);
        chk("sim_busy", 32'(busy), 32'h0004);
        chk("sim_wb_valid", 32'(wb_valid), 1);
        chk("sim_wb_src", 32'(wb_src), 1);
        chk("sim_wb_data", 32'(wb_data), 32'h1234);
        chk("sim_mem_en", 32'(mem_en), 1);
        chk("sim_mem_addr", 32'(mem_addr), 32'h0304);
        step();
        chk("sim_busy_hold", 32'(busy), 32'h0004);
        mem_ready = 1'b1;
        mem_data  = 16'h4321;
        step();
        mem_ready = 1'b0;
        chk("sim_ret2_src", 32'(wb_src), 2);
        chk("sim_ret2_busy", 32'(busy), 0);
        chk("sim_ret2_out", 32'(outstanding), 0);

        // ---- reset mid-flight with 3 loads outstanding ----
        set_req(3, 16'h0400, 4'd9);
        req_valid = 4'b1000;
        step();
        step();
        step();
        req_valid = '0;
        chk("mid_out3", 32'(outstanding), 3);
        chk("mid_busy", 32'(busy), 32'h0200);
        rst_n = 1'b0;
        #1;
        chk("mid_async_out", 32'(outstanding), 0);
        chk("mid_async_busy", 32'(busy), 0);
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 16'hFFFF;
        step();
        mem_ready = 1'b0;
        chk("orph_wb", 32'(wb_valid), 0);
        chk("orph_err", 32'(orphan_err), 1);
        chk("orph_busy", 32'(busy), 0);
        chk("orph_out", 32'(outstanding), 0);
        step();
        chk("orph_sticky", 32'(orphan_err), 1);

`ifdef LOAD_PORT_SCHED_STATS_EN
        // ---- statistics: fill FIFO, then 10 stalled cycles ----
        apply_reset();
        chk("st_orphan_clr", 32'(orphan_err), 0);
        req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 16'h0500, 4'(k));
            step();
        end
        chk("st_full", 32'(outstanding), 8);
        for (int k = 0; k < 10; k++) step();
        req_valid = '0;
        chk("st_grants", stat_grants, 8);
        chk("st_stall", stat_stall, 10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
